// File: rtl/hazard_detect_unit_pkg.sv
// hazard_detect_unit_pkg: shared widths, the shadow-pipeline entry type and the source-match helper
//   REG_ADDR_LEN  register-file address width
//   shadow_t      in-flight {dest, wb, mr} record kept per stage
//   HAZ_BUBBLE    zeroed shadow entry inserted on stall, flush or invalid ID
//   src_match     producer in a stage writes a register the ID instruction reads
package hazard_detect_unit_pkg;
  localparam int REG_ADDR_LEN = 5;
  typedef struct packed {
    logic [REG_ADDR_LEN-1:0] dest;
    logic                    wb;
    logic                    mr;
  } shadow_t;
  localparam shadow_t HAZ_BUBBLE = '0;
  // R0 is hardwired, so a write to it never creates a dependency
  function automatic logic src_match(
    input shadow_t                 s,
    input logic [REG_ADDR_LEN-1:0] src1,
    input logic [REG_ADDR_LEN-1:0] src2,
    input logic                    uses_src2
  );
    return s.wb && s.dest != '0 && (s.dest == src1 || (uses_src2 && s.dest == src2));
  endfunction
endpackage

// File: rtl/hazard_detect_unit_sat_counter.sv
// sat_counter: performance counter that counts up on inc and holds at all-ones
//   clk, rst_n  clock and asynchronous active-low reset
//   inc         count this cycle
//   count       current value, never wraps
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: load-use/RAW hazard detection with branch-flush priority and stall/flush counters
//   id_*            ID-stage instruction fields (sources, dest, WB_EN, MEM_R_EN)
//   branch_taken    EXE resolved a taken branch; flushes IF-ID
//   forward_en      forwarding active: only load-use stalls remain
//   hazard_detected bubble the ID instruction; freeze mirrors it for PC/IF-ID
//   flush           clear IF-ID
//   stall_count     saturating count of stall cycles
//   flush_count     saturating count of flush cycles
module hazard_detect_unit #(
  parameter int REG_ADDR_LEN = hazard_detect_unit_pkg::REG_ADDR_LEN,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] id_src1,
  input  logic [REG_ADDR_LEN-1:0] id_src2,
  input  logic                    id_uses_src2,
  input  logic [REG_ADDR_LEN-1:0] id_dest,
  input  logic                    id_wb_en,
  input  logic                    id_mem_r_en,
  input  logic                    branch_taken,
  input  logic                    forward_en,
  output logic                    hazard_detected,
  output logic                    freeze,
  output logic                    flush,
  output logic [CNT_W-1:0]        stall_count,
  output logic [CNT_W-1:0]        flush_count
);
  import hazard_detect_unit_pkg::*;
  shadow_t exe, mem;
  logic match_exe, match_mem, raw_hazard;
  assign match_exe = src_match(exe, id_src1, id_src2, id_uses_src2);
  assign match_mem = src_match(mem, id_src1, id_src2, id_uses_src2);
  // With forwarding only a load in EXE is too late; without it, WB is covered by the write-first register file
  assign raw_hazard = forward_en ? match_exe && exe.mr : match_exe || match_mem;
  // A taken branch means the ID instruction is on the wrong path, so flush wins over stall
  assign flush           = rst_n && branch_taken;
  assign hazard_detected = rst_n && id_valid && raw_hazard && !branch_taken;
  assign freeze          = hazard_detected;
  // The bubble clears match_exe next cycle, which is what ends a stall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      exe <= HAZ_BUBBLE;
      mem <= HAZ_BUBBLE;
    end else begin
      mem <= exe;
      exe <= (hazard_detected || flush || !id_valid) ? HAZ_BUBBLE
                                                     : shadow_t'{id_dest, id_wb_en, id_mem_r_en};
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(hazard_detected), .count(stall_count));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(flush), .count(flush_count));
endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb_hazard_detect_unit: scoreboarded per-cycle checks of hazard/freeze/flush and the counters
module tb_hazard_detect_unit;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0, id_uses_src2 = 1'b0, id_wb_en = 1'b0, id_mem_r_en = 1'b0;
  logic branch_taken = 1'b0, forward_en = 1'b1;
  logic [4:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
  logic hazard_detected, freeze, flush;
  logic [CNT_W-1:0] stall_count, flush_count;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic  haz;
    logic  fl;
    string nm;
  } exp_t;
  exp_t sb[$];

  hazard_detect_unit #(.REG_ADDR_LEN(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src2(id_uses_src2), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .branch_taken(branch_taken), .forward_en(forward_en), .hazard_detected(hazard_detected),
    .freeze(freeze), .flush(flush), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One ID cycle: drive fields, push the expectation, compare at the falling edge, return after the next rising edge
  task automatic step(input logic v, input logic [4:0] s1, input logic [4:0] s2, input logic u2,
                      input logic [4:0] d, input logic wb, input logic mr, input logic br,
                      input logic eh, input logic ef, input string nm);
    exp_t e;
    id_valid = v; id_src1 = s1; id_src2 = s2; id_uses_src2 = u2;
    id_dest = d; id_wb_en = wb; id_mem_r_en = mr; branch_taken = br;
    sb.push_back('{eh, ef, nm});
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (hazard_detected !== e.haz) begin
      failures++;
      $display("FAIL %s hazard_detected got=%b want=%b", e.nm, hazard_detected, e.haz);
    end
    checks++;
    if (freeze !== e.haz) begin
      failures++;
      $display("FAIL %s freeze got=%b want=%b", e.nm, freeze, e.haz);
    end
    checks++;
    if (flush !== e.fl) begin
      failures++;
      $display("FAIL %s flush got=%b want=%b", e.nm, flush, e.fl);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_uses_src2 = 0;
    id_dest = 0; id_wb_en = 0; id_mem_r_en = 0; branch_taken = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    id_valid = 1; id_src1 = 2; branch_taken = 1;
    #2;
    checks++;
    if ({hazard_detected, freeze, flush} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=000", {hazard_detected, freeze, flush});
    end
    checks++;
    if (stall_count !== '0 || flush_count !== '0) begin
      failures++;
      $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_count, flush_count);
    end
    do_reset();
    step(1, 5'd2, 5'd2, 1, 5'd3, 1, 1, 0, 0, 0, "first_cycle_after_reset");
  endtask

  task automatic test_load_use();
    forward_en = 1;
    do_reset();
    step(1, 5'd0, 5'd0, 0, 5'd2, 1, 1, 0, 0, 0, "lu_ld");
    step(1, 5'd2, 5'd4, 1, 5'd3, 1, 0, 0, 1, 0, "lu_stall");
    step(1, 5'd2, 5'd4, 1, 5'd3, 1, 0, 0, 0, 0, "lu_proceed");
    checks++;
    if (stall_count !== 4'd1) begin
      failures++;
      $display("FAIL lu_stall_count got=%0d want=1", stall_count);
    end
    // load consumed through src2 only
    step(1, 5'd0, 5'd0, 0, 5'd9, 1, 1, 0, 0, 0, "lu2_ld");
    step(1, 5'd1, 5'd9, 1, 5'd3, 1, 0, 0, 1, 0, "lu2_src2_stall");
    step(1, 5'd1, 5'd9, 1, 5'd3, 1, 0, 0, 0, 0, "lu2_proceed");
  endtask

  task automatic test_no_forward();
    forward_en = 0;
    do_reset();
    step(1, 5'd0, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0, "nf_addi");
    step(1, 5'd5, 5'd1, 1, 5'd6, 1, 0, 0, 1, 0, "nf_stall_exe");
    step(1, 5'd5, 5'd1, 1, 5'd6, 1, 0, 0, 1, 0, "nf_stall_mem");
    step(1, 5'd5, 5'd1, 1, 5'd6, 1, 0, 0, 0, 0, "nf_proceed");
    checks++;
    if (stall_count !== 4'd2) begin
      failures++;
      $display("FAIL nf_stall_count got=%0d want=2", stall_count);
    end
    forward_en = 1;
    do_reset();
    step(1, 5'd0, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0, "fw_addi");
    step(1, 5'd5, 5'd1, 1, 5'd6, 1, 0, 0, 0, 0, "fw_no_stall");
    checks++;
    if (stall_count !== 4'd0) begin
      failures++;
      $display("FAIL fw_stall_count got=%0d want=0", stall_count);
    end
  endtask

  task automatic test_masking();
    forward_en = 1;
    do_reset();
    step(1, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0, 0, 0, "r0_ld");
    step(1, 5'd0, 5'd0, 1, 5'd1, 1, 0, 0, 0, 0, "r0_add");
    step(1, 5'd0, 5'd0, 0, 5'd7, 1, 1, 0, 0, 0, "m_ld");
    step(1, 5'd1, 5'd7, 0, 5'd8, 1, 0, 0, 0, 0, "m_addi_src2_unused");
    // invalid ID instruction must not enter the shadow pipeline, nor stall
    step(0, 5'd0, 5'd0, 0, 5'd4, 1, 1, 0, 0, 0, "inv_ld");
    step(1, 5'd4, 5'd0, 0, 5'd8, 1, 0, 0, 0, 0, "inv_user");
    step(1, 5'd0, 5'd0, 0, 5'd4, 1, 1, 0, 0, 0, "inv2_ld");
    step(0, 5'd4, 5'd0, 0, 5'd8, 1, 0, 0, 0, 0, "inv2_id_invalid");
  endtask

  task automatic test_branch_priority();
    forward_en = 1;
    do_reset();
    step(1, 5'd0, 5'd0, 0, 5'd2, 1, 1, 0, 0, 0, "br_ld");
    step(1, 5'd2, 5'd4, 1, 5'd3, 1, 0, 1, 0, 1, "br_flush");
    step(1, 5'd2, 5'd4, 1, 5'd3, 1, 0, 0, 0, 0, "br_after");
    checks++;
    if (flush_count !== 4'd1 || stall_count !== 4'd0) begin
      failures++;
      $display("FAIL br_counters got=%0d/%0d want=1/0", flush_count, stall_count);
    end
  endtask

  task automatic test_reset_mid_stall();
    forward_en = 1;
    do_reset();
    step(1, 5'd0, 5'd0, 0, 5'd2, 1, 1, 0, 0, 0, "rs_ld");
    id_valid = 1; id_src1 = 2; id_src2 = 4; id_uses_src2 = 1; id_dest = 3; id_wb_en = 1; id_mem_r_en = 0;
    #2;
    checks++;
    if (hazard_detected !== 1'b1) begin
      failures++;
      $display("FAIL rs_pre_stall got=%b want=1", hazard_detected);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hazard_detected, freeze, flush} !== 3'b000) begin
      failures++;
      $display("FAIL rs_outputs got=%b want=000", {hazard_detected, freeze, flush});
    end
    checks++;
    if (stall_count !== '0 || flush_count !== '0) begin
      failures++;
      $display("FAIL rs_counters got=%0d/%0d want=0/0", stall_count, flush_count);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 5'd2, 5'd4, 1, 5'd3, 1, 0, 0, 0, 0, "rs_after_add");
    step(1, 5'd3, 5'd4, 1, 5'd5, 1, 0, 0, 0, 0, "rs_after_next");
  endtask

  task automatic test_saturation();
    forward_en = 1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 5'd0, 5'd0, 0, 5'd2, 1, 1, 0, 0, 0, "sat_ld");
      step(1, 5'd2, 5'd4, 1, 5'd3, 1, 0, 0, 1, 0, "sat_stall");
      step(1, 5'd2, 5'd4, 1, 5'd3, 1, 0, 0, 0, 0, "sat_proceed");
      if (i == 14) begin
        checks++;
        if (stall_count !== 4'd15) begin
          failures++;
          $display("FAIL sat_reach got=%0d want=15", stall_count);
        end
      end
    end
    checks++;
    if (stall_count !== 4'd15) begin
      failures++;
      $display("FAIL sat_hold got=%0d want=15", stall_count);
    end
    for (int i = 0; i < 18; i++) step(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1, "sat_flush");
    checks++;
    if (flush_count !== 4'd15) begin
      failures++;
      $display("FAIL sat_flush_hold got=%0d want=15", flush_count);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_forward();
    test_masking();
    test_branch_priority();
    test_reset_mid_stall();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
